// File: rtl/fpu_issue_controller_if.sv
// Handshake bundle for fpu_issue_controller: execute-side request, FPU
// operation/ready pair and the writeback strobe. The master modport is the
// controller; the slave modport is the surrounding execute stage plus FPU.
`ifndef FPU_ADD
`define FPU_ADD  2'b00
`endif
`ifndef FPU_SUB
`define FPU_SUB  2'b01
`endif
`ifndef FPU_MUL
`define FPU_MUL  2'b10
`endif
`ifndef FPU_SQRT
`define FPU_SQRT 2'b11
`endif

interface fpu_issue_controller_if #(
  parameter int WIDTH    = 32,
  parameter int RD_WIDTH = 5
);
  logic                req_valid;
  logic                req_ready;
  logic [1:0]          req_op;
  logic [WIDTH-1:0]    req_operand_1;
  logic [WIDTH-1:0]    req_operand_2;
  logic [RD_WIDTH-1:0] req_rd;
  logic                flush;
  logic [1:0]          fpu_operation;
  logic [WIDTH-1:0]    fpu_operand_1;
  logic [WIDTH-1:0]    fpu_operand_2;
  logic [WIDTH-1:0]    fpu_result;
  logic                fpu_ready;
  logic                wb_valid;
  logic [RD_WIDTH-1:0] wb_rd;
  logic [WIDTH-1:0]    wb_data;
  logic                busy;
  logic                timeout_error;

  modport master (
    input  req_valid, req_op, req_operand_1, req_operand_2, req_rd, flush,
           fpu_result, fpu_ready,
    output req_ready, fpu_operation, fpu_operand_1, fpu_operand_2,
           wb_valid, wb_rd, wb_data, busy, timeout_error
  );

  modport slave (
    output req_valid, req_op, req_operand_1, req_operand_2, req_rd, flush,
           fpu_result, fpu_ready,
    input  req_ready, fpu_operation, fpu_operand_1, fpu_operand_2,
           wb_valid, wb_rd, wb_data, busy, timeout_error
  );
endinterface

// File: rtl/fpu_issue_controller.sv
// Requester-side sequencer for the fixed-point FPU operation/ready handshake.
// One request at a time: IDLE -> ISSUE -> WAIT -> SETTLE -> IDLE. Outside
// ISSUE/WAIT the FPU sees FPU_ADD with zero operands so its MUL/SQRT stage
// machines restart between requests.
// Optional macro FPU_TIMEOUT_EN: abort WAIT after TIMEOUT_CYCLES cycles with
// a zero-data writeback flagged by timeout_error.
module fpu_issue_controller #(
  parameter int WIDTH          = 32,
  parameter int FBITS          = 10,
  parameter int RD_WIDTH       = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic reset,
  fpu_issue_controller_if.master bus
);

  // FBITS only documents the Q format; reject formats with no integer part.
  generate
    if (FBITS >= WIDTH || TIMEOUT_CYCLES < 1) begin : g_cfg_err
      $error("fpu_issue_controller: FBITS must be < WIDTH and TIMEOUT_CYCLES >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, SETTLE} state_t;

  state_t              state, state_nxt;
  logic [1:0]          op_q;
  logic [WIDTH-1:0]    opa_q, opb_q;
  logic [RD_WIDTH-1:0] rd_q;
  logic                wb_set, wb_tmo, tmo_hit, drive;

`ifdef FPU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  // Count WAIT cycles; cleared while the request is being issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               tmo_cnt <= '0;
    else if (state == ISSUE) tmo_cnt <= '0;
    else if (state == WAIT)  tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Fires in the WAIT cycle in which the count reaches TIMEOUT_CYCLES.
  assign tmo_hit = (state == WAIT) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state; flush beats ready, ready beats timeout.
  always_comb begin
    state_nxt = state;
    wb_set    = 1'b0;
    wb_tmo    = 1'b0;
    case (state)
      IDLE:   if (bus.req_valid) state_nxt = ISSUE;
      ISSUE:  state_nxt = bus.flush ? SETTLE : WAIT;  // ready ignored: may be stale
      WAIT: begin
        if (bus.flush) begin
          state_nxt = SETTLE;
        end else if (bus.fpu_ready) begin
          state_nxt = SETTLE;
          wb_set    = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = SETTLE;
          wb_tmo    = 1'b1;
        end
      end
      SETTLE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch: captured on the accept edge, held until the next accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= `FPU_ADD;
      opa_q <= '0;
      opb_q <= '0;
      rd_q  <= '0;
    end else if (state == IDLE && bus.req_valid) begin
      op_q  <= bus.req_op;
      opa_q <= bus.req_operand_1;
      opb_q <= bus.req_operand_2;
      rd_q  <= bus.req_rd;
    end
  end

  // Writeback register: one-cycle strobe during SETTLE, data held afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.wb_valid      <= 1'b0;
      bus.timeout_error <= 1'b0;
      bus.wb_data       <= '0;
      bus.wb_rd         <= '0;
    end else begin
      bus.wb_valid      <= wb_set | wb_tmo;
      bus.timeout_error <= wb_tmo;
      if (wb_set) begin
        bus.wb_data <= bus.fpu_result;
        bus.wb_rd   <= rd_q;
      end else if (wb_tmo) begin
        bus.wb_data <= '0;
        bus.wb_rd   <= rd_q;
      end
    end
  end

  assign drive             = (state == ISSUE) || (state == WAIT);
  assign bus.req_ready     = (state == IDLE);
  assign bus.busy          = (state != IDLE);
  assign bus.fpu_operation = drive ? op_q  : `FPU_ADD;
  assign bus.fpu_operand_1 = drive ? opa_q : '0;
  assign bus.fpu_operand_2 = drive ? opb_q : '0;

endmodule

// File: tb/tb_fpu_issue_controller.sv
// Randomized bench for fpu_issue_controller with a behavioural FPU stub
// (random MUL/SQRT latency, random stale ready) and a transaction-level
// timeline model of each request.
module tb_fpu_issue_controller;
  localparam int FB  = 10;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  fpu_issue_controller_if #(.WIDTH(32), .RD_WIDTH(5)) bus ();

  fpu_issue_controller #(.WIDTH(32), .FBITS(FB), .RD_WIDTH(5), .TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Fixed-point reference arithmetic, Q22.10.
  function automatic logic [31:0] fx(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    logic [63:0] rad, r, t;
    case (op)
      `FPU_ADD: return a + b;
      `FPU_SUB: return a - b;
      `FPU_MUL: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p[FB+31:FB];
      end
      default: begin
        rad = {32'd0, a} << FB;
        r = 64'd0;
        for (int i = 31; i >= 0; i--) begin
          t = r | (64'd1 << i);
          if (t * t <= rad) r = t;
        end
        return r[31:0];
      end
    endcase
  endfunction

  // FPU stub: ADD/SUB answer at once (so ready is also high during ISSUE);
  // MUL/SQRT answer once the inputs have been stable for stub_lat samples,
  // with random stale ready in the cycle the inputs change.
  int          stub_lat = 0;
  int          scnt = 0;
  logic [65:0] last = '0;
  logic [65:0] cur;
  logic        rdy;
  always @(negedge clk) begin
    cur = {bus.fpu_operation, bus.fpu_operand_1, bus.fpu_operand_2};
    if (cur != last) begin
      last = cur;
      scnt = 0;
    end else begin
      scnt++;
    end
    if (cur[65:64] == `FPU_ADD || cur[65:64] == `FPU_SUB) rdy = 1'b1;
    else if (scnt == 0) rdy = 1'($urandom_range(0, 1));
    else rdy = (scnt >= stub_lat);
    bus.fpu_ready  = rdy;
    bus.fpu_result = rdy ? fx(cur[65:64], cur[63:32], cur[31:0]) : $urandom;
  end

  // One request, entered and left at a negedge in IDLE. Timeline in cycles
  // after the accept edge: 1 = ISSUE, 2..w = WAIT, w+1 = SETTLE, w+2 = IDLE.
  task automatic run_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int lat, input int flush_at, input bit junk);
    int  first, w, settle;
    bit  abort, tmo;
    logic [31:0] exp_data;
    stub_lat = lat;
    chk("idle_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_operand_1 = a;
    bus.req_operand_2 = b;
    bus.req_rd = rd;
    bus.flush = junk;  // flush in IDLE must not block the accept
    first = (op == `FPU_ADD || op == `FPU_SUB) ? 1 : ((lat < 1) ? 1 : lat);
    tmo = 1'b0;
`ifdef FPU_TIMEOUT_EN
    if (first > TMO) begin
      first = TMO;
      tmo = 1'b1;
    end
`endif
    w = 1 + first;
    abort = (flush_at >= 1 && flush_at <= w);
    if (abort) w = flush_at;
    settle = w + 1;
    exp_data = tmo ? 32'd0 : fx(op, a, b);
    for (int c = 1; c <= settle + 1; c++) begin
      @(negedge clk);
      chk("busy", 32'(bus.busy), 32'(c <= settle));
      chk("req_ready", 32'(bus.req_ready), 32'(c > settle));
      chk("fpu_op", 32'(bus.fpu_operation), (c <= w) ? 32'(op) : 32'(`FPU_ADD));
      chk("fpu_opa", bus.fpu_operand_1, (c <= w) ? a : 32'd0);
      chk("fpu_opb", bus.fpu_operand_2, (c <= w) ? b : 32'd0);
      chk("wb_valid", 32'(bus.wb_valid), 32'(c == settle && !abort));
      if (c == settle && !abort) begin
        chk("wb_data", bus.wb_data, exp_data);
        chk("wb_rd", 32'(bus.wb_rd), 32'(rd));
        chk("timeout_error", 32'(bus.timeout_error), 32'(tmo));
      end
      bus.flush = (flush_at == c);
      bus.req_valid = junk && (c <= settle);
      if (bus.req_valid) begin
        bus.req_op = 2'($urandom);
        bus.req_operand_1 = $urandom;
        bus.req_operand_2 = $urandom;
        bus.req_rd = 5'($urandom);
      end
    end
    bus.flush = 1'b0;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op = `FPU_ADD;
    bus.req_operand_1 = '0;
    bus.req_operand_2 = '0;
    bus.req_rd = '0;
    bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    chk("rst_tmo", 32'(bus.timeout_error), 32'd0);
    chk("rst_fpu_op", 32'(bus.fpu_operation), 32'(`FPU_ADD));
    chk("rst_fpu_opa", bus.fpu_operand_1, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_txn(`FPU_ADD, 32'h400, 32'h200, 5'd3, 0, 0, 1'b0);
    run_txn(`FPU_MUL, 32'h600, 32'h800, 5'd7, 4, 0, 1'b0);
    run_txn(`FPU_SQRT, 32'h1000, 32'h0, 5'd9, 3, 0, 1'b0);
    run_txn(`FPU_SQRT, 32'h1000, 32'h0, 5'd10, 3, 0, 1'b1);
    run_txn(`FPU_SQRT, 32'h1000, 32'h0, 5'd11, 20, 5, 1'b0);
    run_txn(`FPU_SUB, 32'h800, 32'hC00, 5'd12, 0, 0, 1'b0);
    run_txn(`FPU_MUL, 32'h1234, 32'h5678, 5'd13, 2, 3, 1'b0);  // flush wins over ready

    // Reset in WAIT of a MUL drops the request.
    stub_lat = 20;
    bus.req_valid = 1'b1;
    bus.req_op = `FPU_MUL;
    bus.req_operand_1 = 32'h600;
    bus.req_operand_2 = 32'h800;
    bus.req_rd = 5'd5;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("mid_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("mid_rst_fpu_op", 32'(bus.fpu_operation), 32'(`FPU_ADD));
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
      chk("post_rst_busy", 32'(bus.busy), 32'd0);
    end

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      run_txn(2'($urandom), $urandom, $urandom, 5'($urandom), int'($urandom_range(0, 6)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0,
              1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
